// File: rtl/ysyx_24110015_core_seq.sv
// Multi-cycle core sequencer: fetch, execute, optional load/store, write-back, halt on trap.
// Optional macro YSYX_24110015_PERF_CNT_EN enables the cycle and retired-instruction counters.
module ysyx_24110015_core_seq #(
  parameter int unsigned        XLEN     = 32,
  parameter logic [XLEN-1:0]    RESET_PC = XLEN'(32'h8000_0000),
  parameter int unsigned        TIMEOUT  = 255
) (
  input  logic            clk,
  input  logic            rst,
  output logic            if_req_valid,
  input  logic            if_req_ready,
  output logic [XLEN-1:0] if_req_addr,
  input  logic            if_rsp_valid,
  input  logic [31:0]     if_rsp_data,
  input  logic            if_rsp_err,
  input  logic            dec_mem,
  input  logic            dec_halt,
  input  logic            rf_wen_in,
  input  logic [XLEN-1:0] pc_next,
  output logic            ls_req_valid,
  input  logic            ls_req_ready,
  input  logic            ls_rsp_valid,
  input  logic            ls_rsp_err,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] pc,
  output logic            rf_wen,
  output logic            halted,
  output logic [1:0]      trap_cause,
  output logic [63:0]     cycle_cnt,
  output logic [63:0]     instret_cnt
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_IWAIT,
    S_EXEC,
    S_MREQ,
    S_MWAIT,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [1:0] {
    TRAP_EBREAK  = 2'd0,
    TRAP_IF_ERR  = 2'd1,
    TRAP_LS_ERR  = 2'd2,
    TRAP_TIMEOUT = 2'd3
  } trap_e;

  localparam int unsigned WCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  trap_e           trap_q, trap_d;
  logic [WCW-1:0]  wait_cnt, wait_d;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     inst_q;
  logic            in_wait;
  logic            timeout_hit;

  assign in_wait = (state_q == S_FETCH) || (state_q == S_IWAIT) ||
                   (state_q == S_MREQ)  || (state_q == S_MWAIT);

  // The TIMEOUT-th consecutive cycle in a bus state is the last one allowed.
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == WCW'(TIMEOUT - 1));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    trap_d  = trap_q;
    case (state_q)
      S_FETCH: begin
        if (if_req_ready) begin
          state_d = S_IWAIT;
        end else if (timeout_hit) begin
          state_d = S_HALT;
          trap_d  = TRAP_TIMEOUT;
        end
      end
      S_IWAIT: begin
        if (if_rsp_valid) begin
          if (if_rsp_err) begin
            state_d = S_HALT;
            trap_d  = TRAP_IF_ERR;
          end else begin
            state_d = S_EXEC;
          end
        end else if (timeout_hit) begin
          state_d = S_HALT;
          trap_d  = TRAP_TIMEOUT;
        end
      end
      S_EXEC: begin
        if (dec_halt) begin
          state_d = S_HALT;
          trap_d  = TRAP_EBREAK;
        end else if (dec_mem) begin
          state_d = S_MREQ;
        end else begin
          state_d = S_WB;
        end
      end
      S_MREQ: begin
        if (ls_req_ready) begin
          state_d = S_MWAIT;
        end else if (timeout_hit) begin
          state_d = S_HALT;
          trap_d  = TRAP_TIMEOUT;
        end
      end
      S_MWAIT: begin
        if (ls_rsp_valid) begin
          if (ls_rsp_err) begin
            state_d = S_HALT;
            trap_d  = TRAP_LS_ERR;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout_hit) begin
          state_d = S_HALT;
          trap_d  = TRAP_TIMEOUT;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Wait counter restarts on any state change and only advances while stalled on the bus.
  always_comb begin
    wait_d = '0;
    if ((TIMEOUT != 0) && in_wait && (state_d == state_q)) begin
      wait_d = wait_cnt + WCW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      trap_q   <= TRAP_EBREAK;
      wait_cnt <= '0;
      pc_q     <= RESET_PC;
      inst_q   <= '0;
    end else begin
      state_q  <= state_d;
      trap_q   <= trap_d;
      wait_cnt <= wait_d;
      if ((state_q == S_IWAIT) && if_rsp_valid && !if_rsp_err) begin
        inst_q <= if_rsp_data;
      end
      if (state_q == S_WB) begin
        pc_q <= pc_next;
      end
    end
  end

  // Strobes are forced low while rst is held so nothing leaks out before the first reset edge.
  assign if_req_valid = !rst && (state_q == S_FETCH);
  assign ls_req_valid = !rst && (state_q == S_MREQ);
  assign rf_wen       = !rst && (state_q == S_WB) && rf_wen_in;
  assign halted       = !rst && (state_q == S_HALT);
  assign if_req_addr  = pc_q;
  assign pc           = pc_q;
  assign inst         = inst_q;
  assign trap_cause   = trap_q;

`ifdef YSYX_24110015_PERF_CNT_EN
  logic [63:0] cycle_q;
  logic [63:0] instret_q;
  logic        retire;

  // An ebreak counts as retired even though it never reaches write-back.
  assign retire = (state_q == S_WB) || ((state_q == S_EXEC) && dec_halt);

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state_q != S_HALT) begin
        cycle_q <= cycle_q + 64'd1;
      end
      if (retire) begin
        instret_q <= instret_q + 64'd1;
      end
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_ysyx_24110015_core_seq.sv
// Self-checking bench for ysyx_24110015_core_seq: a cycle-schedule model built from the
// instruction latency rules drives randomized bus timing and checks every output each cycle.
module tb_ysyx_24110015_core_seq;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int          TO     = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_valid;
  logic        if_req_ready = 1'b0;
  logic [31:0] if_req_addr;
  logic        if_rsp_valid = 1'b0;
  logic [31:0] if_rsp_data = '0;
  logic        if_rsp_err = 1'b0;
  logic        dec_mem = 1'b0;
  logic        dec_halt = 1'b0;
  logic        rf_wen_in = 1'b0;
  logic [31:0] pc_next = '0;
  logic        ls_req_valid;
  logic        ls_req_ready = 1'b0;
  logic        ls_rsp_valid = 1'b0;
  logic        ls_rsp_err = 1'b0;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        rf_wen;
  logic        halted;
  logic [1:0]  trap_cause;
  logic [63:0] cycle_cnt;
  logic [63:0] instret_cnt;

  always #5 clk = ~clk;

  ysyx_24110015_core_seq #(
    .XLEN     (32),
    .RESET_PC (RST_PC),
    .TIMEOUT  (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req_valid (if_req_valid),
    .if_req_ready (if_req_ready),
    .if_req_addr  (if_req_addr),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_data  (if_rsp_data),
    .if_rsp_err   (if_rsp_err),
    .dec_mem      (dec_mem),
    .dec_halt     (dec_halt),
    .rf_wen_in    (rf_wen_in),
    .pc_next      (pc_next),
    .ls_req_valid (ls_req_valid),
    .ls_req_ready (ls_req_ready),
    .ls_rsp_valid (ls_rsp_valid),
    .ls_rsp_err   (ls_rsp_err),
    .inst         (inst),
    .pc           (pc),
    .rf_wen       (rf_wen),
    .halted       (halted),
    .trap_cause   (trap_cause),
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt)
  );

  typedef struct {
    int          if_rdy_dly;
    int          if_rsp_dly;
    logic        if_err;
    logic [31:0] data;
    logic        mem;
    logic        halt;
    logic        wen;
    logic [31:0] pcn;
    int          ls_rdy_dly;
    int          ls_rsp_dly;
    logic        ls_err;
  } inst_t;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [1:0]  m_trap;
  logic [63:0] m_cyc;
  logic [63:0] m_ret;
  logic        stale_ls = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] exp_cyc();
`ifdef YSYX_24110015_PERF_CNT_EN
    return m_cyc;
`else
    return 64'd0;
`endif
  endfunction

  function automatic logic [63:0] exp_ret();
`ifdef YSYX_24110015_PERF_CNT_EN
    return m_ret;
`else
    return 64'd0;
`endif
  endfunction

  // Start a cycle: every input gets a random don't-care value, callers then pin what matters.
  task automatic tick_begin();
    @(negedge clk);
    rst          = 1'b0;
    if_req_ready = 1'($urandom);
    if_rsp_valid = 1'($urandom);
    if_rsp_err   = 1'($urandom);
    if_rsp_data  = $urandom;
    dec_mem      = 1'($urandom);
    dec_halt     = 1'($urandom);
    rf_wen_in    = 1'($urandom);
    pc_next      = $urandom;
    ls_req_ready = 1'($urandom);
    ls_rsp_valid = 1'($urandom);
    ls_rsp_err   = 1'($urandom);
    if (stale_ls) begin
      ls_rsp_valid = 1'b1;
      ls_rsp_err   = 1'b0;
      stale_ls     = 1'b0;
    end
  endtask

  // Flags are {if_req_valid, ls_req_valid, rf_wen, halted}.
  task automatic tick_check(input logic [3:0] fl, input string tag);
    #1;
    check({tag, ".flags"}, {60'd0, if_req_valid, ls_req_valid, rf_wen, halted}, {60'd0, fl});
    check({tag, ".pc"}, {32'd0, pc}, {32'd0, m_pc});
    check({tag, ".if_addr"}, {32'd0, if_req_addr}, {32'd0, m_pc});
    check({tag, ".inst"}, {32'd0, inst}, {32'd0, m_inst});
    check({tag, ".trap"}, {62'd0, trap_cause}, {62'd0, m_trap});
    check({tag, ".cycle_cnt"}, cycle_cnt, exp_cyc());
    check({tag, ".instret_cnt"}, instret_cnt, exp_ret());
  endtask

  task automatic do_reset(input int n);
    m_pc   = RST_PC;
    m_inst = '0;
    m_trap = 2'd0;
    m_cyc  = '0;
    m_ret  = '0;
    for (int i = 0; i < n; i++) begin
      tick_begin();
      rst = 1'b1;
      if (i > 0) tick_check(4'b0000, "reset");
    end
  endtask

  // One bus phase: handshake lands on cycle index dly, unless TO cycles elapse first.
  task automatic wait_phase(input int kind, input int dly, input logic err,
                            input logic [31:0] data, output logic to);
    string      tag;
    logic [3:0] fl;
    to  = 1'b0;
    tag = (kind == 0) ? "fetch" : (kind == 1) ? "iwait" : (kind == 2) ? "mreq" : "mwait";
    fl  = (kind == 0) ? 4'b1000 : (kind == 2) ? 4'b0100 : 4'b0000;
    for (int i = 0; i < TO; i++) begin
      tick_begin();
      case (kind)
        0: if_req_ready = (i == dly);
        1: begin
          if_rsp_valid = (i == dly);
          if_rsp_err   = err;
          if_rsp_data  = data;
        end
        2: ls_req_ready = (i == dly);
        default: begin
          ls_rsp_valid = (i == dly);
          ls_rsp_err   = err;
        end
      endcase
      tick_check(fl, tag);
      m_cyc++;
      if (i == dly) return;
      if (i == TO - 1) to = 1'b1;
    end
  endtask

  task automatic halt_hold(input int n);
    for (int i = 0; i < n; i++) begin
      tick_begin();
      tick_check(4'b0001, "halt");
    end
  endtask

  task automatic run_inst(input inst_t t);
    logic to;
    wait_phase(0, t.if_rdy_dly, 1'b0, 32'd0, to);
    if (to) begin m_trap = 2'd3; return; end
    wait_phase(1, t.if_rsp_dly, t.if_err, t.data, to);
    if (to) begin m_trap = 2'd3; return; end
    if (t.if_err) begin m_trap = 2'd1; return; end
    m_inst = t.data;
    tick_begin();
    dec_halt = t.halt;
    dec_mem  = t.mem;
    tick_check(4'b0000, "exec");
    m_cyc++;
    if (t.halt) begin
      m_ret++;
      m_trap = 2'd0;
      return;
    end
    if (t.mem) begin
      wait_phase(2, t.ls_rdy_dly, 1'b0, 32'd0, to);
      if (to) begin m_trap = 2'd3; return; end
      wait_phase(3, t.ls_rsp_dly, t.ls_err, 32'd0, to);
      if (to) begin m_trap = 2'd3; return; end
      if (t.ls_err) begin m_trap = 2'd2; return; end
    end
    tick_begin();
    rf_wen_in = t.wen;
    pc_next   = t.pcn;
    tick_check({2'b00, t.wen, 1'b0}, "wb");
    m_cyc++;
    m_ret++;
    m_pc = t.pcn;
  endtask

  function automatic inst_t rand_inst();
    inst_t t;
    t.if_rdy_dly = $urandom_range(0, 3);
    t.if_rsp_dly = $urandom_range(0, 3);
    t.if_err     = 1'b0;
    t.data       = $urandom;
    t.mem        = 1'($urandom);
    t.halt       = 1'b0;
    t.wen        = 1'($urandom);
    t.pcn        = ($urandom_range(0, 3) == 0) ? 32'($urandom) : m_pc + 32'd4;
    t.ls_rdy_dly = $urandom_range(0, 3);
    t.ls_rsp_dly = $urandom_range(0, 3);
    t.ls_err     = 1'b0;
    return t;
  endfunction

  function automatic inst_t plain_inst(input logic mem, input logic [31:0] pcn);
    inst_t t;
    t = '{0, 0, 1'b0, 32'h0000_0013, mem, 1'b0, 1'b1, pcn, 0, 0, 1'b0};
    return t;
  endfunction

  initial begin
    inst_t t;
    logic  to;

    // Zero-wait ALU instruction: 4 cycles, pc advances after write-back.
    do_reset(3);
    run_inst(plain_inst(1'b0, 32'h8000_0004));
    // Load with ready held low for 3 cycles (handshake lands on the timeout cycle).
    t = plain_inst(1'b1, 32'h8000_0008);
    t.ls_rdy_dly = 3;
    run_inst(t);
    tick_begin();
    tick_check(4'b1000, "after_load");
    m_cyc++;

    // ebreak: halts, pc frozen, instret counts it.
    do_reset(2);
    t = plain_inst(1'b0, 32'h1234_5678);
    t.halt = 1'b1;
    run_inst(t);
    halt_hold(6);

    // Fetch bus error: halt with cause 1 and inst keeps the previous instruction.
    do_reset(2);
    run_inst(rand_inst());
    t = rand_inst();
    t.if_err = 1'b1;
    run_inst(t);
    halt_hold(4);

    // Load/store bus error.
    do_reset(2);
    t = rand_inst();
    t.mem    = 1'b1;
    t.ls_err = 1'b1;
    run_inst(t);
    halt_hold(3);

    // Fetch never accepted: timeout after TO cycles in FETCH.
    do_reset(2);
    t = rand_inst();
    t.if_rdy_dly = 50;
    run_inst(t);
    halt_hold(4);

    // Every handshake on the timeout cycle itself: no halt.
    do_reset(2);
    t = rand_inst();
    t.mem        = 1'b1;
    t.if_rdy_dly = 3;
    t.if_rsp_dly = 3;
    t.ls_rdy_dly = 3;
    t.ls_rsp_dly = 3;
    run_inst(t);
    run_inst(rand_inst());

    // Load/store response never arrives: timeout in MWAIT.
    t = rand_inst();
    t.mem        = 1'b1;
    t.ls_rsp_dly = 40;
    run_inst(t);
    halt_hold(3);

    // Reset during MWAIT, then a stale load/store response in the first fetch cycle.
    do_reset(2);
    t = rand_inst();
    t.mem = 1'b1;
    wait_phase(0, 0, 1'b0, 32'd0, to);
    wait_phase(1, 0, 1'b0, t.data, to);
    m_inst = t.data;
    tick_begin();
    dec_halt = 1'b0;
    dec_mem  = 1'b1;
    tick_check(4'b0000, "exec_abort");
    m_cyc++;
    wait_phase(2, 0, 1'b0, 32'd0, to);
    tick_begin();
    ls_rsp_valid = 1'b0;
    tick_check(4'b0000, "mwait_abort");
    do_reset(2);
    stale_ls = 1'b1;
    run_inst(plain_inst(1'b0, 32'h8000_0004));
    run_inst(rand_inst());

    // Randomized instruction stream.
    do_reset(2);
    for (int k = 0; k < 40; k++) begin
      run_inst(rand_inst());
    end
    t = rand_inst();
    t.halt = 1'b1;
    run_inst(t);
    halt_hold(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
